// File: rtl/fix_tx_scheduler.sv
// Shares the single FIX transmit port between NUM_REQ requesters and a heartbeat
// generator: round-robin grant, hold-until-accepted, running TCP send sequence.
module fix_tx_scheduler #(
   parameter int                      PAYLOAD_LEN = 4,
   parameter int                      NUM_REQ     = 3,
   parameter int                      HB_INTERVAL = 1000,
   parameter logic [PAYLOAD_LEN*8-1:0] HB_PAYLOAD = 32'h4842_0001,
   parameter logic [31:0]             ISN         = 32'h0000_0000
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             enable,
   input  logic [NUM_REQ-1:0]               req_valid,
   input  logic [NUM_REQ*PAYLOAD_LEN*8-1:0] req_data,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic                             tx_ready,
   output logic [PAYLOAD_LEN*8-1:0]         tx_fix_data,
   output logic                             fix_client_valid,
   output logic [31:0]                      tx_seq,
   output logic [3:0]                       grant_id,
   output logic                             hb_sent,
   output logic                             busy
);

   localparam int DATA_W = PAYLOAD_LEN * 8;
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W  = $clog2(HB_INTERVAL);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HB_INTERVAL - 1);

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      GAP
   } state_t;

   state_t           state;
   state_t           next_state;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] rr_next;
   logic [IDX_W-1:0] grant_idx;
   logic [3:0]       cand;
   logic             found;
   logic [CNT_W-1:0] hb_cnt;
   logic             hb_due;
   logic             take_hb;
   logic             take_req;
   logic             accept;

   assign hb_due           = (hb_cnt == CNT_MAX);
   assign accept           = (state == SEND) && tx_ready;
   assign fix_client_valid = (state == SEND);
   assign busy             = (state != IDLE);
   assign rr_next          = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // First pending requester at or after rr_ptr, searching upward with wrap
   always_comb begin
      found     = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = 4'(rr_ptr) + 4'(k);
         if (cand >= 4'(NUM_REQ)) begin
            cand = cand - 4'(NUM_REQ);
         end
         if (!found && req_valid[cand[IDX_W-1:0]]) begin
            found     = 1'b1;
            grant_idx = cand[IDX_W-1:0];
         end
      end
   end

   // Heartbeat outranks pending requests; req_ready is masked while in reset
   always_comb begin
      next_state = state;
      req_ready  = '0;
      take_hb    = 1'b0;
      take_req   = 1'b0;
      case (state)
         IDLE: begin
            if (enable) begin
               if (hb_due) begin
                  take_hb    = 1'b1;
                  next_state = SEND;
               end else if (found) begin
                  take_req             = 1'b1;
                  req_ready[grant_idx] = ~rst;
                  next_state           = SEND;
               end
            end
         end
         SEND: begin
            if (tx_ready) begin
               next_state = GAP;
            end
         end
         GAP: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr      <= '0;
         tx_seq      <= ISN;
         tx_fix_data <= '0;
         grant_id    <= '0;
         hb_sent     <= 1'b0;
      end else begin
         hb_sent <= accept && (grant_id == 4'(NUM_REQ));
         if (take_hb) begin
            tx_fix_data <= HB_PAYLOAD;
            grant_id    <= 4'(NUM_REQ);
         end else if (take_req) begin
            tx_fix_data <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
            grant_id    <= 4'(grant_idx);
            rr_ptr      <= rr_next;
         end
         if (accept) begin
            tx_seq <= tx_seq + 32'(PAYLOAD_LEN);
         end
      end
   end

   // Idle timer only runs outside SEND, so a heartbeat never preempts a message
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hb_cnt <= '0;
      end else if (accept) begin
         hb_cnt <= '0;
      end else if (enable && (state != SEND) && !hb_due) begin
         hb_cnt <= hb_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fix_tx_scheduler.sv
// Randomized bench for fix_tx_scheduler: a cycle-level reference model predicts
// each message into a scoreboard that a separate monitor drains on acceptance.
module tb_fix_tx_scheduler;

   localparam int          NUM_REQ = 3;
   localparam int          HB      = 8;
   localparam logic [31:0] TB_HB   = 32'h4842_0001;
   localparam logic [31:0] TB_ISN  = 32'hFFFF_FFF8;
   localparam int          PH_IDLE = 0;
   localparam int          PH_SEND = 1;
   localparam int          PH_GAP  = 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   enable;
   logic [NUM_REQ-1:0]     req_valid;
   logic [NUM_REQ*32-1:0]  req_data;
   logic [NUM_REQ-1:0]     req_ready;
   logic                   tx_ready;
   logic [31:0]            tx_fix_data;
   logic                   fix_client_valid;
   logic [31:0]            tx_seq;
   logic [3:0]             grant_id;
   logic                   hb_sent;
   logic                   busy;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  gid;
      logic [31:0] seq;
   } exp_t;

   exp_t sb[$];

   int n_checks  = 0;
   int n_errors  = 0;
   int acc_count = 0;
   int hb_seen   = 0;

   int m_phase = PH_IDLE;
   int m_cnt   = 0;
   int m_rr    = 0;
   int m_gid   = 0;
   int m_hb    = 0;
   int m_grant_idx = -1;
   logic [31:0] m_seq = TB_ISN;
   int mb_phase;
   int mg;
   int mdue;
   int midx;
   logic [NUM_REQ-1:0] m_exp_ready;

   int en_mode  = 0;
   int rdy_mode = 0;
   int rand_req = 0;
   logic [NUM_REQ-1:0] refill = '0;

   fix_tx_scheduler #(
      .PAYLOAD_LEN (4),
      .NUM_REQ     (NUM_REQ),
      .HB_INTERVAL (HB),
      .HB_PAYLOAD  (TB_HB),
      .ISN         (TB_ISN)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .enable           (enable),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_ready        (req_ready),
      .tx_ready         (tx_ready),
      .tx_fix_data      (tx_fix_data),
      .fix_client_valid (fix_client_valid),
      .tx_seq           (tx_seq),
      .grant_id         (grant_id),
      .hb_sent          (hb_sent),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model: evaluated mid-cycle with inputs stable, it checks this
   // cycle's outputs and then steps to the state the DUT should have next cycle
   always @(negedge clk) begin
      if (rst) begin
         m_phase     = PH_IDLE;
         m_cnt       = 0;
         m_rr        = 0;
         m_gid       = 0;
         m_hb        = 0;
         m_seq       = TB_ISN;
         m_grant_idx = -1;
         sb.delete();
      end else begin
         mdue        = (m_cnt >= HB - 1) ? 1 : 0;
         mg          = -1;
         m_exp_ready = '0;
         if (m_phase == PH_IDLE && enable && mdue == 0) begin
            for (int k = 0; k < NUM_REQ; k++) begin
               midx = (m_rr + k) % NUM_REQ;
               if (mg < 0 && req_valid[midx]) mg = midx;
            end
            if (mg >= 0) m_exp_ready[mg] = 1'b1;
         end
         check_output("req_ready", 32'(req_ready), 32'(m_exp_ready));
         check_output("fix_client_valid", 32'(fix_client_valid), (m_phase == PH_SEND) ? 32'd1 : 32'd0);
         check_output("busy", 32'(busy), (m_phase != PH_IDLE) ? 32'd1 : 32'd0);
         check_output("tx_seq", tx_seq, m_seq);
         check_output("hb_sent", 32'(hb_sent), 32'(m_hb));

         mb_phase    = m_phase;
         m_hb        = 0;
         m_grant_idx = -1;
         if (mb_phase == PH_IDLE) begin
            if (enable && mdue != 0) begin
               sb.push_back('{data: TB_HB, gid: 4'(NUM_REQ), seq: m_seq});
               m_gid   = NUM_REQ;
               m_phase = PH_SEND;
            end else if (enable && mg >= 0) begin
               sb.push_back('{data: req_data[mg*32 +: 32], gid: 4'(mg), seq: m_seq});
               m_gid       = mg;
               m_rr        = (mg + 1) % NUM_REQ;
               m_grant_idx = mg;
               m_phase     = PH_SEND;
            end
         end else if (mb_phase == PH_SEND) begin
            if (tx_ready) begin
               m_seq   = m_seq + 32'd4;
               m_cnt   = 0;
               m_hb    = (m_gid == NUM_REQ) ? 1 : 0;
               m_phase = PH_GAP;
            end
         end else begin
            m_phase = PH_IDLE;
         end
         if (enable && mb_phase != PH_SEND && m_cnt < HB - 1) m_cnt++;
      end
   end

   // Monitor: every presented message must match the scoreboard head, held
   // unchanged until the cycle in which the downstream accepts it
   always @(negedge clk) begin
      if (!rst) begin
         if (hb_sent) hb_seen++;
         if (fix_client_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("[TB] FAIL unexpected_message: got data 0x%0h id %0d, expected none", tx_fix_data, grant_id);
            end else begin
               check_output("sb_data", tx_fix_data, sb[0].data);
               check_output("sb_grant_id", 32'(grant_id), 32'(sb[0].gid));
               check_output("sb_seq", tx_seq, sb[0].seq);
               if (tx_ready) begin
                  void'(sb.pop_front());
                  acc_count++;
               end
            end
         end
      end
   end

   task automatic apply_stimulus(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         #1;
         if (en_mode == 2) enable = ($urandom_range(0, 7) != 0);
         if (rdy_mode == 2) tx_ready = 1'($urandom_range(0, 1));
         for (int i = 0; i < NUM_REQ; i++) begin
            if (m_grant_idx == i) begin
               req_valid[i] = 1'b0;
               if (refill[i]) begin
                  req_valid[i]          = 1'b1;
                  req_data[i*32 +: 32]  = $urandom;
               end
            end else if (rand_req != 0) begin
               if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                  req_valid[i]         = 1'b1;
                  req_data[i*32 +: 32] = $urandom;
               end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
                  req_valid[i] = 1'b0;
               end
            end
         end
      end
   endtask

   task automatic settle();
      en_mode   = 0;
      rdy_mode  = 0;
      rand_req  = 0;
      refill    = '0;
      enable    = 1'b0;
      tx_ready  = 1'b1;
      req_valid = '0;
      apply_stimulus(4);
   endtask

   int   base;
   int   found_due;
   logic [31:0] seq_before;
   logic [31:0] wrap_exp [3];

   initial begin
      rst       = 1'b1;
      enable    = 1'b1;
      req_valid = '1;
      req_data  = '0;
      tx_ready  = 1'b0;
      wrap_exp[0] = 32'hFFFF_FFFC;
      wrap_exp[1] = 32'h0000_0000;
      wrap_exp[2] = 32'h0000_0004;

      repeat (2) @(posedge clk);
      #1;
      check_output("rst_tx_seq", tx_seq, TB_ISN);
      check_output("rst_tx_fix_data", tx_fix_data, 32'h0);
      check_output("rst_valid", 32'(fix_client_valid), 32'd0);
      check_output("rst_req_ready", 32'(req_ready), 32'd0);
      check_output("rst_grant_id", 32'(grant_id), 32'd0);
      check_output("rst_hb_sent", 32'(hb_sent), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);

      $display("[TB] single request");
      rst        = 1'b0;
      req_valid  = 3'b010;
      req_data[32 +: 32] = 32'hDEAD_BEEF;
      tx_ready   = 1'b1;
      #1;
      check_output("single_req_ready", 32'(req_ready), 32'b010);
      apply_stimulus(1);
      #1;
      check_output("single_valid", 32'(fix_client_valid), 32'd1);
      check_output("single_data", tx_fix_data, 32'hDEAD_BEEF);
      check_output("single_grant_id", 32'(grant_id), 32'd1);
      check_output("single_seq_before", tx_seq, TB_ISN);
      apply_stimulus(1);
      #1;
      check_output("single_seq_after", tx_seq, TB_ISN + 32'd4);
      apply_stimulus(1);

      $display("[TB] round-robin fairness");
      refill    = 3'b111;
      req_valid = 3'b111;
      for (int i = 0; i < NUM_REQ; i++) req_data[i*32 +: 32] = $urandom;
      base = acc_count;
      apply_stimulus(27);
      refill    = '0;
      req_valid = '0;
      check_output("rr_msg_count", 32'(acc_count - base), 32'd9);
      settle();

      $display("[TB] backpressure");
      enable     = 1'b1;
      tx_ready   = 1'b0;
      seq_before = m_seq;
      req_valid[2]        = 1'b1;
      req_data[64 +: 32]  = $urandom;
      apply_stimulus(6);
      tx_ready = 1'b1;
      apply_stimulus(3);
      #1;
      check_output("bp_one_increment", tx_seq, seq_before + 32'd4);
      settle();

      $display("[TB] heartbeat");
      enable   = 1'b1;
      tx_ready = 1'b1;
      base     = hb_seen;
      for (int c = 0; c < 30 && hb_seen == base; c++) apply_stimulus(1);
      check_output("hb_fired", 32'(hb_seen - base), 32'd1);
      found_due = 0;
      for (int c = 0; c < 40 && found_due == 0; c++) begin
         apply_stimulus(1);
         if (m_phase == PH_IDLE && m_cnt == HB - 1) begin
            found_due          = 1;
            req_valid[0]       = 1'b1;
            req_data[0 +: 32]  = $urandom;
         end
      end
      if (found_due == 0) begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL hb_due_timeout: got no due cycle, expected one within 40 cycles");
      end else begin
         #1;
         check_output("hb_priority_ready", 32'(req_ready), 32'd0);
         apply_stimulus(1);
         #1;
         check_output("hb_priority_id", 32'(grant_id), 32'd3);
         check_output("hb_priority_data", tx_fix_data, TB_HB);
         apply_stimulus(6);
      end
      settle();

      $display("[TB] enable drop during send");
      enable   = 1'b1;
      tx_ready = 1'b0;
      req_valid[0]       = 1'b1;
      req_data[0 +: 32]  = $urandom;
      apply_stimulus(2);
      enable = 1'b0;
      req_valid[1]       = 1'b1;
      req_valid[2]       = 1'b1;
      req_data[32 +: 32] = $urandom;
      req_data[64 +: 32] = $urandom;
      apply_stimulus(2);
      tx_ready = 1'b1;
      apply_stimulus(6);
      #1;
      check_output("en_low_busy", 32'(busy), 32'd0);
      check_output("en_low_req_ready", 32'(req_ready), 32'd0);
      enable = 1'b1;
      apply_stimulus(10);
      settle();

      $display("[TB] reset during send");
      enable   = 1'b1;
      tx_ready = 1'b0;
      req_valid[1]       = 1'b1;
      req_data[32 +: 32] = $urandom;
      apply_stimulus(2);
      #1;
      rst = 1'b1;
      #1;
      check_output("async_rst_valid", 32'(fix_client_valid), 32'd0);
      check_output("async_rst_busy", 32'(busy), 32'd0);
      check_output("async_rst_seq", tx_seq, TB_ISN);
      check_output("async_rst_data", tx_fix_data, 32'h0);
      check_output("async_rst_grant_id", 32'(grant_id), 32'd0);
      check_output("async_rst_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] sequence wrap");
      enable   = 1'b1;
      tx_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_valid[k]         = 1'b1;
         req_data[k*32 +: 32] = $urandom;
         apply_stimulus(4);
         #1;
         check_output("wrap_seq", tx_seq, wrap_exp[k]);
      end

      $display("[TB] random traffic");
      en_mode  = 2;
      rdy_mode = 2;
      rand_req = 1;
      apply_stimulus(3000);
      settle();
      check_output("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fix_tx_scheduler.md
# fix_tx_scheduler

Controller that shares the single FIX transmit input of `network_top` (`rx_fix_data` / `fix_client_valid`) between several FIX message requesters plus an internal heartbeat generator. It round-robin arbitrates pending requests, injects a heartbeat after a configurable idle period, and holds each message until the downstream accepts it. It also maintains the running TCP send sequence number, advanced by `PAYLOAD_LEN` per accepted message. It sits between the order-generation logic and `network_top`.

## Interface

- `PAYLOAD_LEN`, 4, message payload size in bytes; data width is `PAYLOAD_LEN*8`.
- `NUM_REQ`, 3, number of requesters (2..8).
- `HB_INTERVAL`, 1000, idle cycles before a heartbeat is due (≥ 4).
- `HB_PAYLOAD`, 32'h4842_0001, heartbeat payload, `PAYLOAD_LEN*8` bits.
- `ISN`, 32'h0000_0000, initial TCP send sequence number.

- `clk`, in, 1, system clock; all state changes on the rising edge.
- `rst`, in, 1, asynchronous, active-high reset.
- `enable`, in, 1, permits new grants and heartbeat counting.
- `req_valid`, in, `NUM_REQ`, per-requester message pending.
- `req_data`, in, `NUM_REQ*PAYLOAD_LEN*8`, payloads; requester i uses slice i.
- `req_ready`, out, `NUM_REQ`, one-hot; high for the cycle in which requester i's data is captured.
- `tx_ready`, in, 1, downstream accepts the presented message this cycle.
- `tx_fix_data`, out, `PAYLOAD_LEN*8`, message presented to `network_top`.
- `fix_client_valid`, out, 1, `tx_fix_data` is valid.
- `tx_seq`, out, 32, sequence number of the message being presented or next to be sent.
- `grant_id`, out, 4, source of the current message; `NUM_REQ` denotes a heartbeat.
- `hb_sent`, out, 1, one-cycle pulse on heartbeat acceptance.
- `busy`, out, 1, state is not IDLE.

## Operation

- FSM states: IDLE, SEND, GAP.
- IDLE: if `enable`=0, stay. Otherwise, if `hb_due`=1, load `HB_PAYLOAD`, set `grant_id`=`NUM_REQ`, and go to SEND. No `req_ready` is asserted in that case.
- IDLE, else: if any `req_valid` is set, the grant goes to the first set bit at or after `rr_ptr`, searching upward with wrap. `req_ready[g]` is asserted combinationally in that cycle. On the edge, capture the data slice, set `grant_id`=g, set `rr_ptr`=(g+1) mod `NUM_REQ`, and go to SEND.
- SEND: `fix_client_valid`=1 and `tx_fix_data` is held stable. On an edge with `tx_ready`=1: `tx_seq` += `PAYLOAD_LEN` (mod 2^32), the heartbeat counter clears, `hb_sent` pulses if `grant_id`=`NUM_REQ`, and the FSM goes to GAP. SEND ignores `enable`; an in-flight message always completes.
- GAP: one cycle with `fix_client_valid`=0, then IDLE. This keeps back-to-back messages from sharing a cycle with the registered encoder.
- Heartbeat counter: increments on each cycle with `enable`=1 while in IDLE or GAP. It saturates at `HB_INTERVAL`-1, which sets `hb_due`. It clears on any acceptance.
- Requesters must hold `req_valid` and data until they see `req_ready`. Dropping `req_valid` before grant withdraws the request with no side effect.
- `rr_ptr` is unchanged by heartbeats.

## Timing

- Reset values: state IDLE, `rr_ptr`=0, counter 0, `hb_due`=0, `tx_seq`=`ISN`, `tx_fix_data`=0, `fix_client_valid`=0, `req_ready`=0, `grant_id`=0, `hb_sent`=0, `busy`=0.
- Reset asserted mid-SEND drops the message immediately. `tx_seq` returns to `ISN`.
- Latency: `req_valid` seen in IDLE at cycle N gives `req_ready` in cycle N and `fix_client_valid` in cycle N+1.
- If `tx_ready` is already high in cycle N+1: GAP in N+2, IDLE in N+3. The sustained maximum is one message per 3 cycles.
- `tx_seq` updates on the same edge that accepts the message. It reads the new value from the next cycle onward.
- `hb_due` and a request together in IDLE: the heartbeat wins and the request waits.
- Counter reaching saturation while in SEND is not possible because it is cleared there. Reaching saturation in GAP makes the heartbeat eligible in the following IDLE cycle.
- Sequence wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000. No flag is raised.

## Test plan

- Reset and single request: after `rst`, raise `req_valid`=3'b010 with data 32'hDEADBEEF and hold `tx_ready`=1. Expect `req_ready`=3'b010 in the same cycle, `fix_client_valid` with 32'hDEADBEEF the next cycle, then `tx_seq` goes 0→4 and `grant_id`=1.
- Round-robin fairness: hold `req_valid`=3'b111 with `tx_ready`=1 for 9 messages. Expect grant order 0,1,2,0,1,2,0,1,2, one message every 3 cycles, and final `tx_seq`=36.
- Backpressure: hold `tx_ready`=0 for 5 cycles during SEND. Expect `fix_client_valid` and the data stable for those 5 cycles, `tx_seq` unchanged, and exactly one increment when `tx_ready` rises.
- Heartbeat: with `HB_INTERVAL`=8, idle with `enable`=1 and no requests. Expect `fix_client_valid` with 32'h48420001, `grant_id`=3, `hb_sent` pulse, and `tx_seq`+4. Then raise `req_valid` in the IDLE cycle where `hb_due`=1; the heartbeat must go first.
- Enable and reset mid-operation: drop `enable` during SEND. The message must still complete, and no grant may occur while `enable`=0. Then assert `rst` during SEND. All outputs must drop to reset values asynchronously, before the next clock edge.
- Sequence wrap: with `ISN`=32'hFFFF_FFF8, send 3 messages. Expect `tx_seq` to go FFFF_FFF8→FFFF_FFFC→0000_0000→0000_0004.
